// File: rtl/multi_port_ram.sv
// Purpose : single-clock, N-port, byte-maskable RAM with per-port status reporting.
// Latency : response read_latency edges after the request sample edge; fully pipelined.
// Backpressure: none; every port accepts one request per cycle and never stalls.
//
// Ports (port p occupies slice p of each packed vector, port 0 in the LSBs):
//   port_clk  : clock
//   reset     : synchronous, active-high; clears the response pipeline, not the storage
//   re / we   : per-port read / write enable (a request is sampled when re|we)
//   addr      : per-port byte address, address_width bits each
//   wdata     : per-port write data, 8*word_size bits each
//   wmask     : per-port byte write mask, word_size bits each
//   rsp_valid : per-port one-cycle response strobe
//   rdata     : per-port read data (holds its last value between responses)
//   status    : per-port 3-bit code: 0 READY, 2 OUT_OF_BOUNDS, 3 MISALIGNED,
//               4 READONLY, 5 DUAL_WRITE (1 WAIT and 6 WRITEONLY are reserved)
//
// Optional build macro MULTI_PORT_RAM_WRITE_PROTECT_EN adds protect_base/protect_limit:
// writes inside [protect_base, protect_limit] are rejected with READONLY.

module multi_port_ram #(
  parameter int port_count    = 2,
  parameter int word_size     = 4,
  parameter int word_count    = 256,
  parameter int address_width = 32,
  parameter int read_latency  = 2
) (
  input  logic                                 port_clk,
  input  logic                                 reset,
`ifdef MULTI_PORT_RAM_WRITE_PROTECT_EN
  input  logic [address_width-1:0]             protect_base,
  input  logic [address_width-1:0]             protect_limit,
`endif
  input  logic [port_count-1:0]                re,
  input  logic [port_count-1:0]                we,
  input  logic [port_count*address_width-1:0]  addr,
  input  logic [port_count*8*word_size-1:0]    wdata,
  input  logic [port_count*word_size-1:0]      wmask,
  output logic [port_count-1:0]                rsp_valid,
  output logic [port_count*8*word_size-1:0]    rdata,
  output logic [port_count*3-1:0]              status
);

  localparam int WORD_W    = 8 * word_size;
  localparam int BYTE_BITS = $clog2(word_size);
  localparam int IDX_W     = $clog2(word_count);
  // Stage 0 captures the request at its sample edge; read_latency further
  // stages put the response on the outputs exactly read_latency edges later.
  localparam int DEPTH     = read_latency + 1;

  localparam logic [63:0]              MEM_BYTES  = 64'(word_count) * 64'(word_size);
  localparam logic [address_width-1:0] ALIGN_MASK = address_width'(word_size - 1);

  localparam logic [2:0] ST_READY = 3'd0;
  localparam logic [2:0] ST_OOB   = 3'd2;
  localparam logic [2:0] ST_MIS   = 3'd3;
  localparam logic [2:0] ST_RO    = 3'd4;
  localparam logic [2:0] ST_DUAL  = 3'd5;

  if (read_latency < 1 || read_latency > 4) begin : g_bad_latency
    $error("multi_port_ram: read_latency must be in 1..4, got %0d", read_latency);
  end

  // Storage: never reset, so contents survive a reset pulse.
  logic [WORD_W-1:0] mem_q [word_count];

  // Per-port request decode
  logic [address_width-1:0] a   [port_count];
  logic [IDX_W-1:0]         idx [port_count];
  logic [port_count-1:0]    req;
  logic [port_count-1:0]    oob;
  logic [port_count-1:0]    mis;
  logic [port_count-1:0]    prot;
  logic [port_count-1:0]    wr_cand;
  logic [port_count-1:0]    dual;
  logic [port_count-1:0]    commit;
  logic [2:0]               sts_d [port_count];
  logic [WORD_W-1:0]        rd_d  [port_count];

  always_comb begin
    req     = '0;
    oob     = '0;
    mis     = '0;
    prot    = '0;
    wr_cand = '0;
    dual    = '0;
    commit  = '0;
    for (int p = 0; p < port_count; p++) begin
      a[p]     = addr[p*address_width +: address_width];
      idx[p]   = a[p][BYTE_BITS +: IDX_W];
      sts_d[p] = ST_READY;
      rd_d[p]  = '0;
    end

    for (int p = 0; p < port_count; p++) begin
      req[p] = re[p] | we[p];
      oob[p] = (64'(a[p]) >= MEM_BYTES);
      mis[p] = |(a[p] & ALIGN_MASK);
`ifdef MULTI_PORT_RAM_WRITE_PROTECT_EN
      // An inverted range (base > limit) can never satisfy both bounds.
      prot[p] = we[p] && (a[p] >= protect_base) && (a[p] <= protect_limit);
`endif
      // Only writes that pass every earlier check take part in collision detection.
      wr_cand[p] = we[p] & ~oob[p] & ~mis[p] & ~prot[p];
    end

    // Same-cycle writes to one word cancel each other, whatever their masks.
    for (int p = 0; p < port_count; p++) begin
      for (int q = 0; q < port_count; q++) begin
        if (q != p && wr_cand[p] && wr_cand[q] && idx[p] == idx[q]) begin
          dual[p] = 1'b1;
        end
      end
    end

    for (int p = 0; p < port_count; p++) begin
      commit[p] = wr_cand[p] & ~dual[p] & ~reset;

      if (oob[p])       sts_d[p] = ST_OOB;
      else if (mis[p])  sts_d[p] = ST_MIS;
      else if (prot[p]) sts_d[p] = ST_RO;
      else if (dual[p]) sts_d[p] = ST_DUAL;
      else              sts_d[p] = ST_READY;

      // Read-first: data is taken from the array before this edge's writes land.
      if (sts_d[p] == ST_READY) rd_d[p] = mem_q[idx[p]];
    end
  end

  // Byte-granular write commit. Committing ports never share a word, so the
  // loop order never decides a winner.
  always_ff @(posedge port_clk) begin
    for (int p = 0; p < port_count; p++) begin
      for (int b = 0; b < word_size; b++) begin
        if (commit[p] && wmask[p*word_size + b]) begin
          mem_q[idx[p]][b*8 +: 8] <= wdata[p*WORD_W + b*8 +: 8];
        end
      end
    end
  end

  // Response pipeline. Valid bits shift every cycle; data and status only move
  // with a valid entry, so the final stage holds the last response.
  logic [port_count-1:0] vld_q [DEPTH];
  logic [WORD_W-1:0]     dat_q [DEPTH][port_count];
  logic [2:0]            sts_q [DEPTH][port_count];

  always_ff @(posedge port_clk) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        vld_q[s] <= '0;
        for (int p = 0; p < port_count; p++) begin
          dat_q[s][p] <= '0;
          sts_q[s][p] <= ST_READY;
        end
      end
    end else begin
      vld_q[0] <= req;
      for (int p = 0; p < port_count; p++) begin
        if (req[p]) begin
          dat_q[0][p] <= rd_d[p];
          sts_q[0][p] <= sts_d[p];
        end
      end
      for (int s = 1; s < DEPTH; s++) begin
        vld_q[s] <= vld_q[s-1];
        for (int p = 0; p < port_count; p++) begin
          if (vld_q[s-1][p]) begin
            dat_q[s][p] <= dat_q[s-1][p];
            sts_q[s][p] <= sts_q[s-1][p];
          end
        end
      end
    end
  end

  // Outputs come straight from registers: no input-to-output combinational path.
  always_comb begin
    rsp_valid = vld_q[DEPTH-1];
    rdata     = '0;
    status    = '0;
    for (int p = 0; p < port_count; p++) begin
      rdata[p*WORD_W +: WORD_W] = dat_q[DEPTH-1][p];
      status[p*3 +: 3]          = sts_q[DEPTH-1][p];
    end
  end

endmodule

// File: tb/tb_multi_port_ram.sv
module tb_multi_port_ram;

  logic        port_clk = 1'b0;
  logic        reset    = 1'b1;
  logic [1:0]  re       = '0;
  logic [1:0]  we       = '0;
  logic [63:0] addr     = '0;
  logic [63:0] wdata    = '0;
  logic [7:0]  wmask    = '0;
  logic [1:0]  rsp_valid;
  logic [63:0] rdata;
  logic [5:0]  status;

  int tests = 0;
  int fails = 0;

  always #5 port_clk = ~port_clk;

  multi_port_ram #(
    .port_count(2), .word_size(4), .word_count(256),
    .address_width(32), .read_latency(2)
  ) dut (
    .port_clk     (port_clk),
    .reset        (reset),
`ifdef MULTI_PORT_RAM_WRITE_PROTECT_EN
    .protect_base (32'hFFFF_FFFF),
    .protect_limit(32'h0000_0000),
`endif
    .re           (re),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .wmask        (wmask),
    .rsp_valid    (rsp_valid),
    .rdata        (rdata),
    .status       (status)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge port_clk);
    #1;
  endtask

  task automatic clr();
    re = '0; we = '0; addr = '0; wdata = '0; wmask = '0;
  endtask

  task automatic drive(input int p, input logic r, input logic w, input logic [31:0] ad,
                       input logic [31:0] d, input logic [3:0] m);
    re[p] = r;
    we[p] = w;
    addr[p*32 +: 32]  = ad;
    wdata[p*32 +: 32] = d;
    wmask[p*4 +: 4]   = m;
  endtask

  task automatic chk(input string tag, input int p, input logic v, input logic [2:0] st);
    tests++;
    assert (rsp_valid[p] === v) else begin
      fails++;
      $error("FAIL %s rsp_valid[%0d]: observed %b expected %b", tag, p, rsp_valid[p], v);
    end
    if (v) begin
      tests++;
      assert (status[p*3 +: 3] === st) else begin
        fails++;
        $error("FAIL %s status[%0d]: observed %0d expected %0d", tag, p, status[p*3 +: 3], st);
      end
    end
  endtask

  task automatic chk_data(input string tag, input int p, input logic [31:0] d);
    tests++;
    assert (rdata[p*32 +: 32] === d) else begin
      fails++;
      $error("FAIL %s rdata[%0d]: observed %h expected %h", tag, p, rdata[p*32 +: 32], d);
    end
  endtask

  task automatic chkd(input string tag, input int p, input logic v, input logic [2:0] st,
                      input logic [31:0] d);
    chk(tag, p, v, st);
    chk_data(tag, p, d);
  endtask

  task automatic chk_zero(input string tag, input int p);
    chk(tag, p, 1'b0, 3'd0);
    chk_data(tag, p, 32'h0);
    tests++;
    assert (status[p*3 +: 3] === 3'd0) else begin
      fails++;
      $error("FAIL %s status[%0d]: observed %0d expected 0", tag, p, status[p*3 +: 3]);
    end
  endtask

  initial begin
    // Reset state
    clr();
    reset = 1'b1;
    step(); step();
    chk_zero("rst_p0", 0);
    chk_zero("rst_p1", 1);
    reset = 1'b0;

    // Basic write then read, latency 2
    drive(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF); step();
    clr(); drive(0, 1, 0, 32'h10, 0, 0);       step();
    clr();                                      step();
    chk("t1_wr_rsp", 0, 1, 3'd0);
    chk("t1_p1_idle", 1, 0, 3'd0);
    step();
    chkd("t1_rd", 0, 1, 3'd0, 32'hDEADBEEF);
    step();
    chk("t1_no_rsp", 0, 0, 3'd0);
    chk_data("t1_hold", 0, 32'hDEADBEEF);

    // Byte mask
    clr(); drive(0, 0, 1, 32'h20, 32'h11223344, 4'hF);    step();
    clr(); drive(0, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101); step();
    clr(); drive(0, 1, 0, 32'h20, 0, 0);                  step();
    clr(); step();
    chk("t2_mask_wr", 0, 1, 3'd0);
    step();
    chkd("t2_mask_rd", 0, 1, 3'd0, 32'h11BB33DD);

    // Dual-write collision
    clr(); drive(0, 0, 1, 32'h40, 32'h5, 4'hF); step();
    clr(); drive(0, 0, 1, 32'h40, 32'h1, 4'hF); drive(1, 0, 1, 32'h40, 32'h2, 4'hF); step();
    clr(); drive(0, 1, 0, 32'h40, 0, 0); step();
    clr(); step();
    chkd("t3_col_p0", 0, 1, 3'd5, 32'h0);
    chkd("t3_col_p1", 1, 1, 3'd5, 32'h0);
    step();
    chkd("t3_unchanged", 0, 1, 3'd0, 32'h5);

    // Read-first across ports
    clr(); drive(0, 0, 1, 32'h8, 32'h7, 4'hF); step();
    clr(); drive(0, 0, 1, 32'h8, 32'h99, 4'hF); drive(1, 1, 0, 32'h8, 0, 0); step();
    clr(); drive(1, 1, 0, 32'h8, 0, 0); step();
    clr(); step();
    chkd("t4_old", 1, 1, 3'd0, 32'h7);
    step();
    chkd("t4_new", 1, 1, 3'd0, 32'h99);

    // re=we=1 on one port returns the old word
    clr(); drive(0, 1, 1, 32'h8, 32'h55, 4'hF); step();
    clr(); drive(1, 1, 0, 32'h8, 0, 0); step();
    clr(); step();
    chkd("t4_rw_old", 0, 1, 3'd0, 32'h99);
    step();
    chkd("t4_rw_new", 1, 1, 3'd0, 32'h55);

    // Out-of-bounds and misaligned, reads and writes
    clr(); drive(0, 1, 0, 32'h400, 0, 0); drive(1, 1, 0, 32'h3, 0, 0); step();
    clr(); drive(0, 0, 1, 32'h11, 32'h0, 4'hF); drive(1, 0, 1, 32'h410, 32'h0, 4'hF); step();
    clr(); drive(0, 1, 0, 32'h10, 0, 0); step();
    clr();
    chkd("t5_oob_rd", 0, 1, 3'd2, 32'h0);
    chkd("t5_mis_rd", 1, 1, 3'd3, 32'h0);
    step();
    chkd("t5_mis_wr", 0, 1, 3'd3, 32'h0);
    chkd("t5_oob_wr", 1, 1, 3'd2, 32'h0);
    step();
    chkd("t5_intact", 0, 1, 3'd0, 32'hDEADBEEF);

    // Non-colliding writes from both ports commit together
    clr(); drive(0, 0, 1, 32'h44, 32'hA0A0A0A0, 4'hF); drive(1, 0, 1, 32'h48, 32'hB1B1B1B1, 4'hF); step();
    clr(); drive(0, 1, 0, 32'h48, 0, 0); drive(1, 1, 0, 32'h44, 0, 0); step();
    clr(); step();
    chk("t6_wr_p0", 0, 1, 3'd0);
    chk("t6_wr_p1", 1, 1, 3'd0);
    step();
    chkd("t6_rd_p0", 0, 1, 3'd0, 32'hB1B1B1B1);
    chkd("t6_rd_p1", 1, 1, 3'd0, 32'hA0A0A0A0);

    // Zero-mask write is a READY no-op
    clr(); drive(0, 0, 1, 32'h48, 32'hFFFFFFFF, 4'h0); step();
    clr(); drive(0, 1, 0, 32'h48, 0, 0); step();
    clr(); step();
    chk("t6_nop_wr", 0, 1, 3'd0);
    step();
    chkd("t6_nop_rd", 0, 1, 3'd0, 32'hB1B1B1B1);

    // Reset mid-flight
    clr(); drive(0, 0, 1, 32'h64, 32'h0BADF00D, 4'hF); step();
    clr(); step(); step(); step();
    clr(); drive(0, 0, 1, 32'h60, 32'hCAFE0001, 4'hF); drive(1, 1, 0, 32'h10, 0, 0); step();
    clr(); drive(0, 1, 0, 32'h60, 0, 0); drive(1, 0, 1, 32'h64, 32'h12345678, 4'hF);
    reset = 1'b1; step();
    clr();
    chk_zero("t7_rst_p0", 0);
    chk_zero("t7_rst_p1", 1);
    step();
    chk("t7_drop_a0", 0, 0, 3'd0);
    chk("t7_drop_a1", 1, 0, 3'd0);
    reset = 1'b0; step();
    chk("t7_drop_b0", 0, 0, 3'd0);
    chk("t7_drop_b1", 1, 0, 3'd0);
    step();
    chk("t7_drop_c0", 0, 0, 3'd0);
    chk("t7_drop_c1", 1, 0, 3'd0);
    drive(0, 1, 0, 32'h60, 0, 0); drive(1, 1, 0, 32'h64, 0, 0); step();
    clr(); step(); step();
    chkd("t7_kept", 0, 1, 3'd0, 32'hCAFE0001);
    chkd("t7_ignored", 1, 1, 3'd0, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
